// File: rtl/argmax_classifier.sv
// Sequential arg-max over INPUT_NUM IEEE-754 single-precision scores, one element per clock.
// Optional macro ARGMAX_NAN_FILTER_EN: NaN elements never win (an all-NaN input reports index 0).
module argmax_classifier #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INPUT_NUM  = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enb,
  input  logic [DATA_WIDTH*INPUT_NUM-1:0] inputs,
  output logic [3:0]                      classIdx,
  output logic [DATA_WIDTH-1:0]           maxVal,
  output logic                            ackMax
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [3:0] LastIdx = 4'(INPUT_NUM - 1);

  state_e                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [3:0]            r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_best, w_best_nxt;
  logic                  r_ack, w_ack_nxt;
  logic [DATA_WIDTH-1:0] w_elem;
  logic                  w_greater;
  logic                  w_take;

  always_comb begin
    w_elem = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (r_cnt == 4'(i)) w_elem = inputs[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Sign-magnitude ordering on raw bits; +0 and -0 compare equal.
  always_comb begin
    if (w_elem[31] != r_best[31]) begin
      w_greater = !w_elem[31] && ((w_elem[30:0] | r_best[30:0]) != 31'd0);
    end else if (!w_elem[31]) begin
      w_greater = w_elem[30:0] > r_best[30:0];
    end else begin
      w_greater = w_elem[30:0] < r_best[30:0];
    end
  end

`ifdef ARGMAX_NAN_FILTER_EN
  logic w_elem_nan;
  logic w_best_nan;
  assign w_elem_nan = (w_elem[30:23] == 8'hFF) && (w_elem[22:0] != 23'd0);
  assign w_best_nan = (r_best[30:23] == 8'hFF) && (r_best[22:0] != 23'd0);
  // A NaN held as best (only possible from element 0) yields to any real number.
  assign w_take     = !w_elem_nan && (w_best_nan || w_greater);
`else
  assign w_take     = w_greater;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_best_nxt  = r_best;
    w_ack_nxt   = r_ack;
    if (!enb) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = 4'd0;
      w_ack_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_best_nxt  = inputs[DATA_WIDTH-1:0];
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = StScan;
        end
        StScan: begin
          if (w_take) begin
            w_best_nxt = w_elem;
            w_idx_nxt  = r_cnt;
          end
          if (r_cnt == LastIdx) begin
            w_state_nxt = StDone;
            w_ack_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        StDone: begin
          w_ack_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_idx   <= 4'd0;
      r_best  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_best  <= w_best_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign classIdx = r_idx;
  assign maxVal   = r_best;
  assign ackMax   = r_ack;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: stimulus pushes expected results, a monitor checks
// each rising ackMax against the queue head (index, value and latency).
module tb_argmax_classifier;

  localparam int W = 32;
  localparam int N = 10;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enb = 1'b0;
  logic [W*N-1:0] inputs = '0;
  logic [3:0]     classIdx;
  logic [W-1:0]   maxVal;
  logic           ackMax;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic prev_ack = 1'b0;

  argmax_classifier #(
    .DATA_WIDTH(W),
    .INPUT_NUM (N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enb     (enb),
    .inputs  (inputs),
    .classIdx(classIdx),
    .maxVal  (maxVal),
    .ackMax  (ackMax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising ackMax must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ackMax === 1'b1 && prev_ack !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ackMax=1 with no operation pending (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("sb_classIdx", 32'(classIdx), 32'(e.idx));
        check("sb_maxVal", maxVal, e.val);
        check("sb_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_ack = ackMax;
  end

  function automatic logic [W*N-1:0] fill(input logic [31:0] v);
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[W*i +: W] = v;
    return r;
  endfunction

  task automatic wait_ack();
    for (int i = 0; i < 30 && ackMax !== 1'b1; i++) @(negedge clk);
    if (ackMax !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got ackMax=%b, expected 1 within 30 cycles", ackMax);
    end
  endtask

  // Full operation: start, await ack, verify DONE ignores inputs, then release enb.
  task automatic run_op(input logic [W*N-1:0] vec, input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    inputs = vec;
    enb    = 1'b1;
    sb.push_back('{idx: idx, val: val, cyc: cyc + N});
    wait_ack();
    @(negedge clk);
    inputs = ~vec;
    repeat (2) @(negedge clk);
    check("done_hold_idx", 32'(classIdx), 32'(idx));
    check("done_hold_val", maxVal, val);
    check("done_hold_ack", 32'(ackMax), 32'd1);
    enb = 1'b0;
    @(negedge clk);
    check("drop_ack_low", 32'(ackMax), 32'd0);
    check("drop_keep_idx", 32'(classIdx), 32'(idx));
    check("drop_keep_val", maxVal, val);
  endtask

  initial begin
    logic [W*N-1:0] v;
    #1 reset = 1'b1;
    #2;
    check("reset_classIdx", 32'(classIdx), 32'd0);
    check("reset_maxVal", maxVal, 32'd0);
    check("reset_ackMax", 32'(ackMax), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single peak at element 6.
    v = fill(32'h3C23D70A);
    v[W*6 +: W] = 32'h3F68F5C3;
    run_op(v, 4'd6, 32'h3F68F5C3);

    // All equal: lowest index wins.
    run_op(fill(32'h3DCCCCCD), 4'd0, 32'h3DCCCCCD);

    // Mixed signs: +0 wins, -0 at index 3 must not displace it.
    v = fill(32'hBF400000);
    v[W*0 +: W] = 32'hBF800000;
    v[W*1 +: W] = 32'hBF000000;
    v[W*2 +: W] = 32'h00000000;
    v[W*3 +: W] = 32'h80000000;
    v[W*4 +: W] = 32'hC0000000;
    run_op(v, 4'd2, 32'h00000000);

    // -0 loaded first, +0 at index 1 is equal, not greater.
    v = fill(32'hBF800000);
    v[W*0 +: W] = 32'h80000000;
    v[W*1 +: W] = 32'h00000000;
    run_op(v, 4'd0, 32'h80000000);

    // Denormals ordered by raw bits.
    v = fill(32'h00000000);
    v[W*4 +: W] = 32'h00000003;
    v[W*8 +: W] = 32'h007FFFFF;
    v[W*9 +: W] = 32'h00000005;
    run_op(v, 4'd8, 32'h007FFFFF);

    // All -Inf except -2.0 at the last index.
    v = fill(32'hFF800000);
    v[W*9 +: W] = 32'hC0000000;
    run_op(v, 4'd9, 32'hC0000000);

    // Abort mid-scan, restart with new inputs.
    @(negedge clk);
    inputs = fill(32'h3F000000);
    enb    = 1'b1;
    repeat (4) @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    check("abort_ack_low", 32'(ackMax), 32'd0);
    v = fill(32'h3E000000);
    v[W*9 +: W] = 32'h3F800000;
    inputs = v;
    enb    = 1'b1;
    sb.push_back('{idx: 4'd9, val: 32'h3F800000, cyc: cyc + N});
    wait_ack();
    @(negedge clk);
    check("abort_restart_idx", 32'(classIdx), 32'd9);
    enb = 1'b0;
    @(negedge clk);

    // NaN at element 2.
    v = fill(32'h3C23D70A);
    v[W*2 +: W] = 32'h7FC00000;
    v[W*5 +: W] = 32'h3F000000;
`ifdef ARGMAX_NAN_FILTER_EN
    run_op(v, 4'd5, 32'h3F000000);
`else
    run_op(v, 4'd2, 32'h7FC00000);
`endif

    // Reset mid-scan clears everything immediately.
    @(negedge clk);
    inputs = fill(32'h40400000);
    enb    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_classIdx", 32'(classIdx), 32'd0);
    check("midreset_maxVal", maxVal, 32'd0);
    check("midreset_ackMax", 32'(ackMax), 32'd0);
    @(negedge clk);
    check("reset_hold_maxVal", maxVal, 32'd0);
    enb   = 1'b0;
    reset = 1'b0;

    // Recovery after reset.
    v = fill(32'hBC23D70A);
    v[W*7 +: W] = 32'h41200000;
    run_op(v, 4'd7, 32'h41200000);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Sequential arg-max over the ten IEEE-754 single-precision class scores produced by the softmax stage; it is the final stage of the CNN inference path. It scans one element per clock, reports the winning class index and its value, and raises an acknowledge that the top-level controller uses as "inference done". Enable/acknowledge semantics match the upstream layers: hold `enb` high to run, drop it to clear.

## Interface
- `DATA_WIDTH`, 32: element width; only 32 (IEEE-754 single) is supported.
- `INPUT_NUM`, 10: number of elements scanned; range 2..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enb` in 1: level enable; high starts/holds an operation, low returns the block to idle.
- `inputs` in DATA_WIDTH*INPUT_NUM: packed scores, element i at `[DATA_WIDTH*i +: DATA_WIDTH]`; must be stable while `enb` is high.
- `classIdx` out 4: index of the maximum element.
- `maxVal` out DATA_WIDTH: value of the maximum element.
- `ackMax` out 1: result valid; high in DONE until `enb` falls.

## Operation
- States: IDLE, SCAN, DONE. 4-bit element counter `cnt`; best-value and best-index registers drive `maxVal` and `classIdx` directly.
- IDLE, `enb`=1: best ← element 0, index ← 0, `cnt` ← 1, go SCAN.
- SCAN: compare element `cnt` against best; if strictly greater, best ← element, index ← `cnt`. If `cnt` = INPUT_NUM-1 go DONE and set `ackMax`, else `cnt` ← `cnt`+1.
- DONE: hold result and `ackMax`=1 while `enb`=1; inputs no longer sampled.
- `enb`=0 in any state: next edge → IDLE, `ackMax` ← 0, `cnt` ← 0; `classIdx`/`maxVal` keep the last result until the next load.
- Float compare (combinational, inside block): signs differ → positive operand greater, except +0 and -0 are equal; both positive → larger `[30:0]` greater; both negative → smaller `[30:0]` greater.
- Ties: strict greater-than only, so the lowest index wins (all-equal input → index 0).
- Denormals compare by raw bits (correct ordering, no flush).

## Timing
- Reset (async, immediate): state IDLE, `cnt`=0, `classIdx`=0, `maxVal`=0, `ackMax`=0.
- Latency: with `enb` sampled high at edge E0, `ackMax` rises after edge E0+INPUT_NUM-1 (edge 10 counting E0 as 1, for INPUT_NUM=10); one element per cycle, no stalls.
- `enb` low for a single cycle mid-SCAN aborts; re-assertion restarts from element 0.
- `reset` mid-operation overrides everything, including a simultaneous `enb` rise.
- New operation requires `enb` low for ≥1 rising edge after DONE.

## Configuration
- `ARGMAX_NAN_FILTER_EN` defined: any element with exponent all-ones and non-zero mantissa never wins; if element 0 is NaN it is loaded, but replaced by the first non-NaN element regardless of compare; if all are NaN, result is index 0 with its NaN value.
- Not defined: NaNs go through the raw-bit compare (positive NaN beats +Inf, negative NaN loses to -Inf); no extra logic.

## Test plan
- Scores 0.01 ×9 with element 6 = 0.91 (0x3F68F5C3) → `classIdx`=6, `maxVal`=0x3F68F5C3, `ackMax` high after 10th edge from `enb` rise.
- All ten = 0x3DCCCCCD (0.1) → `classIdx`=0 (tie rule).
- Mixed signs: {-1.0, -0.5, +0.0, -0.0, -2.0, …all negative} → `classIdx`=2, `maxVal`=0x00000000; element 3 (-0.0) does not displace it.
- Drop `enb` at SCAN cycle 4, re-raise next cycle with new inputs (max at index 9 = 0x3F800000) → `ackMax` low during abort, then `classIdx`=9 after 10 further edges; assert `reset` mid-SCAN → all outputs 0 immediately.
- Element 2 = 0x7FC00000 (NaN), element 5 = 0x3F000000 max of rest → with `ARGMAX_NAN_FILTER_EN` `classIdx`=5; without it `classIdx`=2.
